fifo_stream_reader: RTL and testbench
=====================================

Name: fifo_stream_reader

Overview:
- Read-side adapter that drains a sync FIFO with registered read data and fixed read latency.
- Presents the data as a first-word-fall-through valid/ready stream.
- Holds a small internal skid buffer sized so that streaming sustains one word per cycle with no combinational path from out_ready to fifo_rd_en.
- Sits between every sync_fifo instance and the downstream datapath consumer (PE array, writeback, DDR packer).

Parameters:
- DATA_W, 8, word width; must match the attached FIFO.
- RD_LAT, 1, cycles from an accepted fifo_rd_en to valid fifo_rd_data; legal range 1..4.
- BUF_DEPTH (localparam), RD_LAT+2, skid buffer entries.
- CNT_W (localparam), bw(BUF_DEPTH+1), width of occupancy counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- clr  in  1  synchronous flush: drops buffered and in-flight words.
- fifo_rd_en  out  1  pop request to the FIFO.
- fifo_rd_data  in  DATA_W  FIFO read data, valid RD_LAT cycles after an accepted pop.
- fifo_empty  in  1  FIFO empty flag, accurate in the current cycle.
- out_data  out  DATA_W  stream data; stable while out_valid && !out_ready.
- out_valid  out  1  stream valid.
- out_ready  in  1  downstream accept.
- buf_level  out  CNT_W  number of words held in the skid buffer.

Behaviour:
- Reset (async, rst=1): buffer pointers 0, occupancy 0, in-flight pipeline cleared.
  - out_valid=0, out_data=0, buf_level=0, fifo_rd_en=0.
  - Takes effect immediately regardless of clk.
  - A word in flight at reset is discarded.
- Pop issue: fifo_rd_en = !rst && !clr && !fifo_empty && (occ + inflight < BUF_DEPTH).
  - occ and inflight are registered counts.
  - out_ready and the current-cycle pop do not enter this term.
- In-flight tracking:
  - A shift register of RD_LAT valid bits shifts in fifo_rd_en each cycle.
  - inflight = popcount of that register, or an equivalent counter updated with +issue and -return.
  - When the last stage is set, fifo_rd_data is written into the buffer at wr_ptr.
- Buffer: circular, BUF_DEPTH entries, pointers wrap BUF_DEPTH-1 -> 0.
  - Writes occur only on a returning word.
  - Credit accounting guarantees a write never hits a full buffer. Overflow is a design error; the bench asserts it.
- Output:
  - out_valid = (occ != 0).
  - out_data = buf[rd_ptr], read from registers or LUTRAM, no added latency.
  - A handshake (out_valid && out_ready) advances rd_ptr and decrements occ.
- Simultaneous return and handshake in one cycle: occ unchanged, both pointers advance.
- A return into an empty buffer gives out_valid=1 on the next cycle (first word fall-through). Total latency is RD_LAT+1 cycles from fifo_rd_en.
- Throughput: with FIFO non-empty and out_ready held 1, steady state is one word per cycle after the initial RD_LAT+1 fill.
- Backpressure (out_ready=0): fifo_rd_en stops once occ+inflight reaches BUF_DEPTH. No word is lost or duplicated.
- FIFO goes empty mid-stream: fifo_rd_en deasserts the same cycle. Words already in flight are still captured.
- Ordering: output order equals FIFO pop order.
- clr (sync, has priority over all other events that cycle):
  - Next cycle occ=0, pointers=0, in-flight pipeline zeroed, so returning words are discarded.
  - out_valid=0 next cycle.
  - fifo_rd_en=0 during the clr cycle.
  - A handshake in the clr cycle still counts as accepted downstream.
- buf_level = occ, registered, range 0..BUF_DEPTH.

Test Plan:
- RD_LAT=1, FIFO preloaded 0x01..0x10, out_ready=1 -> first out_valid 2 cycles after first fifo_rd_en; 16 words in order on 16 consecutive cycles; then out_valid=0, fifo_rd_en=0.
- RD_LAT=1, 8 words, out_ready=0 for 10 cycles then 1 -> exactly 3 pops issued, buf_level=3, out_data=0x01 stable while stalled; then 8 words in order, none lost.
- out_ready toggling 1010..., FIFO written 1 word every 3 cycles -> output sequence identical to write sequence; buf_level never exceeds 3; fifo_rd_en never high while fifo_empty=1.
- RD_LAT=3, 20 words, out_ready=1 -> steady one word per cycle after 4-cycle fill; max buf_level <= 5.
- clr pulsed while buf_level=2 with 1 word in flight -> next cycle out_valid=0, buf_level=0; the in-flight word never appears at the output; streaming resumes from the next FIFO word.
- rst asserted asynchronously mid-stream between clock edges -> out_valid, fifo_rd_en and buf_level go 0 immediately; after release, new FIFO contents stream correctly from word 0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side adapter: drains a fixed-latency sync FIFO into a first-word-fall-through
// valid/ready stream through a credit-managed skid buffer.
module fifo_stream_reader #(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  localparam int BUF_DEPTH = RD_LAT + 2,
  localparam int CNT_W = $clog2(BUF_DEPTH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  buf_level
);
  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W-1:0]  inflight;
  logic [RD_LAT-1:0] pipe;
  logic              ret;
  logic              take;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(pipe[i]);
  end

  assign ret       = pipe[RD_LAT-1];
  assign take      = out_valid && out_ready;
  assign out_valid = (occ != '0);
  assign out_data  = mem[rd_ptr];
  assign buf_level = occ;

  // Credits count only registered state, so out_ready never reaches fifo_rd_en.
  assign fifo_rd_en = !rst && !clr && !fifo_empty &&
                      ((occ + inflight) < CNT_W'(BUF_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      pipe   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      pipe   <= '0;
    end else begin
      pipe <= (pipe << 1) | RD_LAT'(fifo_rd_en);
      if (ret) begin
        mem[wr_ptr] <= fifo_rd_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (take) rd_ptr <= bump(rd_ptr);
      if (ret && !take)      occ <= occ + CNT_W'(1);
      else if (!ret && take) occ <= occ - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: one instance at RD_LAT=1, one at RD_LAT=3,
// each fed by a small behavioural sync FIFO with matching read latency.
module tb_fifo_stream_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- instance A, RD_LAT = 1 ----------------
  logic       a_rd_en, a_empty, a_valid, ra;
  logic [7:0] a_rd_data, a_data;
  logic [2:0] a_level;
  logic [7:0] fa_mem [64];
  int         fa_wr = 0, fa_rd = 0;
  logic       fa_flush = 1'b0;

  fifo_stream_reader #(.DATA_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .clr(clr),
    .fifo_rd_en(a_rd_en), .fifo_rd_data(a_rd_data), .fifo_empty(a_empty),
    .out_data(a_data), .out_valid(a_valid), .out_ready(ra), .buf_level(a_level));

  assign a_empty = (fa_wr == fa_rd);
  always @(posedge clk) begin
    if (fa_flush) fa_rd <= fa_wr;
    else if (a_rd_en && !a_empty) begin
      a_rd_data <= fa_mem[fa_rd & 63];
      fa_rd     <= fa_rd + 1;
    end
  end

  // ---------------- instance B, RD_LAT = 3 ----------------
  logic       b_rd_en, b_empty, b_valid, rb;
  logic [7:0] b_rd_data, b_data, s0, s1, s2;
  logic [2:0] b_level;
  logic [7:0] fb_mem [64];
  int         fb_wr = 0, fb_rd = 0;

  fifo_stream_reader #(.DATA_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .clr(clr),
    .fifo_rd_en(b_rd_en), .fifo_rd_data(b_rd_data), .fifo_empty(b_empty),
    .out_data(b_data), .out_valid(b_valid), .out_ready(rb), .buf_level(b_level));

  assign b_empty   = (fb_wr == fb_rd);
  assign b_rd_data = s2;
  always @(posedge clk) begin
    if (b_rd_en && !b_empty) begin
      s0    <= fb_mem[fb_rd & 63];
      fb_rd <= fb_rd + 1;
    end
    s1 <= s0;
    s2 <= s1;
  end

  // ---------------- monitors (sampled on the falling edge) ----------------
  logic [7:0] qa[$], qb[$];
  int qa_cyc[$], qb_cyc[$], rda_cyc[$], rdb_cyc[$];
  int max_a = 0, max_b = 0, viol_a = 0, viol_b = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_rd_en) rda_cyc.push_back(cyc);
      if (a_valid && ra) begin qa.push_back(a_data); qa_cyc.push_back(cyc); end
      if (int'(a_level) > max_a) max_a = int'(a_level);
      if (a_rd_en && a_empty) viol_a++;
      if (b_rd_en) rdb_cyc.push_back(cyc);
      if (b_valid && rb) begin qb.push_back(b_data); qb_cyc.push_back(cyc); end
      if (int'(b_level) > max_b) max_b = int'(b_level);
      if (b_rd_en && b_empty) viol_b++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_a(input logic [7:0] v);
    fa_mem[fa_wr & 63] = v;
    fa_wr++;
  endtask

  task automatic push_b(input logic [7:0] v);
    fb_mem[fb_wr & 63] = v;
    fb_wr++;
  endtask

  int base, base_rd, n;
  bit hit;

  initial begin
    rst = 1'b1; clr = 1'b0; ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 16; i++) push_a(8'(i + 1));
    cycles(3);
    // reset state
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_data",  32'(a_data),  32'd0);
    chk("rst_level", 32'(a_level), 32'd0);
    chk("rst_rd_en", 32'(a_rd_en), 32'd0);

    // T1: 16 preloaded words, out_ready held high
    base = qa.size(); base_rd = rda_cyc.size();
    rst = 1'b0; ra = 1'b1;
    cycles(30);
    chk("t1_count", 32'(qa.size() - base), 32'd16);
    if (qa.size() - base == 16) begin
      chk("t1_latency", 32'(qa_cyc[base] - rda_cyc[base_rd]), 32'd2);
      chk("t1_back_to_back", 32'(qa_cyc[base + 15] - qa_cyc[base]), 32'd15);
      for (int i = 0; i < 16; i++) chk($sformatf("t1_word%0d", i), 32'(qa[base + i]), 32'(i + 1));
    end
    chk("t1_idle_valid", 32'(a_valid), 32'd0);
    chk("t1_idle_rd_en", 32'(a_rd_en), 32'd0);

    // T2: backpressure for 10 cycles, then drain
    ra = 1'b0;
    base = qa.size(); base_rd = rda_cyc.size();
    for (int i = 0; i < 8; i++) push_a(8'(i + 1));
    cycles(10);
    chk("t2_pops", 32'(rda_cyc.size() - base_rd), 32'd3);
    chk("t2_level", 32'(a_level), 32'd3);
    chk("t2_valid", 32'(a_valid), 32'd1);
    chk("t2_data_stall", 32'(a_data), 32'h01);
    cycles(3);
    chk("t2_data_stable", 32'(a_data), 32'h01);
    ra = 1'b1;
    cycles(15);
    chk("t2_count", 32'(qa.size() - base), 32'd8);
    if (qa.size() - base == 8)
      for (int i = 0; i < 8; i++) chk($sformatf("t2_word%0d", i), 32'(qa[base + i]), 32'(i + 1));

    // T3: toggling ready, trickle writes every 3 cycles
    base = qa.size(); n = 0;
    for (int i = 0; i < 36; i++) begin
      ra = ~ra;
      if (i % 3 == 0 && n < 8) begin push_a(8'(8'hA0 + n)); n++; end
      cycles(1);
    end
    ra = 1'b1;
    cycles(10);
    chk("t3_count", 32'(qa.size() - base), 32'd8);
    if (qa.size() - base == 8)
      for (int i = 0; i < 8; i++) chk($sformatf("t3_word%0d", i), 32'(qa[base + i]), 32'(8'hA0 + i));
    chk("t3_max_level_le3", 32'(max_a <= 3), 32'd1);

    // T4: RD_LAT=3, 20 words streaming
    rb = 1'b1;
    base = qb.size(); base_rd = rdb_cyc.size();
    for (int i = 0; i < 20; i++) push_b(8'(8'h40 + i));
    cycles(40);
    chk("t4_count", 32'(qb.size() - base), 32'd20);
    if (qb.size() - base == 20) begin
      chk("t4_latency", 32'(qb_cyc[base] - rdb_cyc[base_rd]), 32'd4);
      chk("t4_back_to_back", 32'(qb_cyc[base + 19] - qb_cyc[base]), 32'd19);
      for (int i = 0; i < 20; i++) chk($sformatf("t4_word%0d", i), 32'(qb[base + i]), 32'(8'h40 + i));
    end
    chk("t4_max_level_le5", 32'(max_b <= 5), 32'd1);

    // T5: clr with two words buffered and one in flight
    ra = 1'b0;
    for (int i = 0; i < 6; i++) push_a(8'(8'h21 + i));
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cycles(1);
      if (a_level == 3'd2) hit = 1'b1;
    end
    chk("t5_reach_level2", 32'(a_level), 32'd2);
    clr = 1'b1;
    #1;
    chk("t5_clr_rd_en", 32'(a_rd_en), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    chk("t5_valid_after_clr", 32'(a_valid), 32'd0);
    chk("t5_level_after_clr", 32'(a_level), 32'd0);
    base = qa.size();
    ra = 1'b1;
    cycles(10);
    chk("t5_count", 32'(qa.size() - base), 32'd3);
    if (qa.size() - base == 3)
      for (int i = 0; i < 3; i++) chk($sformatf("t5_word%0d", i), 32'(qa[base + i]), 32'(8'h24 + i));

    // T6: asynchronous reset mid-stream
    for (int i = 0; i < 10; i++) push_a(8'(8'h51 + i));
    cycles(4);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(a_valid), 32'd0);
    chk("t6_async_rd_en", 32'(a_rd_en), 32'd0);
    chk("t6_async_level", 32'(a_level), 32'd0);
    chk("t6_async_data",  32'(a_data),  32'd0);
    fa_flush = 1'b1;
    @(posedge clk); #1;
    fa_flush = 1'b0;
    cycles(2);
    base = qa.size();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push_a(8'(8'h61 + i));
    cycles(12);
    chk("t6_count", 32'(qa.size() - base), 32'd4);
    if (qa.size() - base == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("t6_word%0d", i), 32'(qa[base + i]), 32'(8'h61 + i));

    chk("a_rd_en_while_empty", 32'(viol_a), 32'd0);
    chk("b_rd_en_while_empty", 32'(viol_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
